// File: rtl/tcm_port_arbiter.sv
// Two-master arbiter for one TCM RAM port: round-robin with burst lock, byte-lane
// write steering, and lane-aligned, sign/zero-extended read responses.
//
// lock_owner | meaning
// -----------|-----------------------------------------------------------
// LOCK_NONE  | no hold; plain round-robin between valid masters
// LOCK_M0    | M0 holds the port while it keeps req_valid_i[0] high
// LOCK_M1    | M1 holds the port while it keeps req_valid_i[1] high
module tcm_port_arbiter #(
    parameter int MAX_PHY_ADDR = 4095,
    parameter int ADDR_WIDTH   = $clog2(MAX_PHY_ADDR + 1),
    parameter int MAX_ADDR     = MAX_PHY_ADDR
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [1:0]              req_valid_i,
    output logic [1:0]              req_ready_o,
    input  logic [1:0]              req_lock_i,
    input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [1:0]              req_we_i,
    input  logic [3:0]              req_size_i,
    input  logic [1:0]              req_unsigned_i,
    input  logic [63:0]             req_wdata_i,
    output logic [1:0]              rsp_valid_o,
    output logic [31:0]             rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [31:0]             ram_wdata_o,
    output logic [3:0]              ram_wr_o,
    input  logic [31:0]             ram_rdata_i
);

    typedef enum logic [1:0] {
        LOCK_NONE = 2'b00,
        LOCK_M0   = 2'b01,
        LOCK_M1   = 2'b10
    } lock_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [31:0] MAX_ADDR_U = 32'(MAX_ADDR);

    // last_grant: 0 = M0, 1 = M1
    lock_t                 lock_owner;
    lock_t                 lock_next;
    logic                  last_grant;
    logic                  last_next;

    logic                  sel;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [1:0]            size;
    logic                  is_unsigned;
    logic                  lock;
    logic [31:0]           wdata;
    logic                  err;
    logic                  addr_over;
    logic [3:0]            strobe;
    logic [31:0]           wdata_rep;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [ADDR_WIDTH-1:0] addr_hold;

    logic                  rsp_pend;
    logic                  rsp_owner;
    logic [1:0]            rsp_size;
    logic [1:0]            rsp_lane;
    logic                  rsp_unsigned;
    logic                  rsp_we;
    logic                  rsp_err;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    always_comb begin
        sel = 1'b0;
        if (lock_owner == LOCK_M1 && req_valid_i[1]) begin
            sel = 1'b1;
        end else if (lock_owner == LOCK_M0 && req_valid_i[0]) begin
            sel = 1'b0;
        end else if (req_valid_i == 2'b10) begin
            sel = 1'b1;
        end else if (req_valid_i == 2'b11) begin
            sel = ~last_grant;
        end
    end

    // Ready is forced low while reset is held, independent of the registered state.
    always_comb begin
        req_ready_o = 2'b00;
        if (rst_n_i) begin
            req_ready_o = sel ? {req_valid_i[1], 1'b0} : {1'b0, req_valid_i[0]};
        end
    end

    assign accept = |req_ready_o;

    always_comb begin
        if (sel) begin
            addr        = req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH];
            we          = req_we_i[1];
            size        = req_size_i[3:2];
            is_unsigned = req_unsigned_i[1];
            lock        = req_lock_i[1];
            wdata       = req_wdata_i[63:32];
        end else begin
            addr        = req_addr_i[ADDR_WIDTH-1:0];
            we          = req_we_i[0];
            size        = req_size_i[1:0];
            is_unsigned = req_unsigned_i[0];
            lock        = req_lock_i[0];
            wdata       = req_wdata_i[31:0];
        end
    end

    assign addr_over = 32'(addr) > MAX_ADDR_U;

    always_comb begin
        err = addr_over;
        case (size)
            SIZE_HALF: if (addr[0])           err = 1'b1;
            SIZE_WORD: if (addr[1:0] != 2'b00) err = 1'b1;
            SIZE_BYTE: ;
            default:                           err = 1'b1;
        endcase
    end

    always_comb begin
        strobe    = 4'b1111;
        wdata_rep = wdata;
        case (size)
            SIZE_BYTE: begin
                strobe    = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                strobe    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign word_addr   = addr >> 2;
    assign ram_addr_o  = accept ? word_addr : addr_hold;
    assign ram_wdata_o = wdata_rep;
    assign ram_wr_o    = (accept && we && !err) ? strobe : 4'b0000;

    // A lock lapses as soon as its owner drops valid, even without a new handshake.
    always_comb begin
        lock_next = lock_owner;
        last_next = last_grant;
        if (accept) begin
            last_next = sel;
            if (lock) begin
                lock_next = sel ? LOCK_M1 : LOCK_M0;
            end else begin
                lock_next = LOCK_NONE;
            end
        end else if ((lock_owner == LOCK_M0 && !req_valid_i[0]) ||
                     (lock_owner == LOCK_M1 && !req_valid_i[1])) begin
            lock_next = LOCK_NONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_owner <= LOCK_NONE;
            last_grant <= 1'b1;
            addr_hold  <= '0;
        end else begin
            lock_owner <= lock_next;
            last_grant <= last_next;
            if (accept) begin
                addr_hold <= word_addr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_pend     <= 1'b0;
            rsp_owner    <= 1'b0;
            rsp_size     <= 2'b00;
            rsp_lane     <= 2'b00;
            rsp_unsigned <= 1'b0;
            rsp_we       <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            rsp_pend <= accept;
            if (accept) begin
                rsp_owner    <= sel;
                rsp_size     <= size;
                rsp_lane     <= addr[1:0];
                rsp_unsigned <= is_unsigned;
                rsp_we       <= we;
                rsp_err      <= err;
            end
        end
    end

    assign rsp_valid_o = rsp_pend ? (rsp_owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_err_o   = rsp_pend & rsp_err;
    assign byte_sel    = ram_rdata_i[{rsp_lane, 3'b000} +: 8];
    assign half_sel    = rsp_lane[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];

    // Read data is formed straight from the RAM output; writes and errors return zero.
    always_comb begin
        rsp_rdata_o = 32'h0;
        if (rsp_pend && !rsp_we && !rsp_err) begin
            case (rsp_size)
                SIZE_BYTE: rsp_rdata_o = {{24{~rsp_unsigned & byte_sel[7]}}, byte_sel};
                SIZE_HALF: rsp_rdata_o = {{16{~rsp_unsigned & half_sel[15]}}, half_sel};
                default:   rsp_rdata_o = ram_rdata_i;
            endcase
        end
    end

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Directed bench for tcm_port_arbiter: a read-first RAM model behind the port and a
// scoreboard queue of expected responses checked by an independent monitor.
module tb_tcm_port_arbiter;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_lock;
    logic [23:0] req_addr;
    logic [1:0]  req_we;
    logic [3:0]  req_size;
    logic [1:0]  req_unsigned;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wr;
    logic [31:0] ram_rdata = 32'h0;

    typedef struct packed {
        logic        owner;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_n    = 0;
    logic [31:0] mem [0:(1<<AW)-1];

    tcm_port_arbiter #(
        .MAX_PHY_ADDR(4095),
        .ADDR_WIDTH  (12),
        .MAX_ADDR    (2047)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_lock_i    (req_lock),
        .req_addr_i    (req_addr),
        .req_we_i      (req_we),
        .req_size_i    (req_size),
        .req_unsigned_i(req_unsigned),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .ram_addr_o    (ram_addr),
        .ram_wdata_o   (ram_wdata),
        .ram_wr_o      (ram_wr),
        .ram_rdata_i   (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Read-first synchronous RAM: the read returns the word as it was before this edge's write.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        for (int i = 0; i < 4; i++) begin
            if (ram_wr[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid !== 2'b00) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: rsp_valid_o=%b with nothing outstanding (cycle %0d)",
                         rsp_valid, cyc_n);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_owner", 32'(rsp_valid), mon_e.owner ? 32'h2 : 32'h1);
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                check("rsp_latency_cycle", 32'(cyc_n), mon_e.due);
            end
        end
    end

    task automatic push(input logic owner, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.owner = owner;
        e.rdata = rdata;
        e.err   = err;
        e.due   = 32'(cyc_n + 1);
        sb_q.push_back(e);
    endtask

    task automatic set_req(input int m, input logic we, input logic [1:0] size,
                           input logic [11:0] addr, input logic [31:0] wdata,
                           input logic uns, input logic lock);
        req_valid[m]          = 1'b1;
        req_we[m]             = we;
        req_size[2*m +: 2]    = size;
        req_addr[12*m +: 12]  = addr;
        req_wdata[32*m +: 32] = wdata;
        req_unsigned[m]       = uns;
        req_lock[m]           = lock;
    endtask

    task automatic clr_req(input int m);
        req_valid[m] = 1'b0;
        req_lock[m]  = 1'b0;
    endtask

    task automatic cyc(input string tag, input logic [1:0] exp_ready, input logic [3:0] exp_wr);
        @(negedge clk);
        check({tag, " ready"}, 32'(req_ready), 32'(exp_ready));
        check({tag, " ram_wr"}, 32'(ram_wr), 32'(exp_wr));
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_data(input string tag, input logic [1:0] exp_ready, input logic [3:0] exp_wr,
                            input logic [11:0] exp_addr, input logic [31:0] exp_wdata);
        @(negedge clk);
        check({tag, " ready"}, 32'(req_ready), 32'(exp_ready));
        check({tag, " ram_wr"}, 32'(ram_wr), 32'(exp_wr));
        check({tag, " ram_addr"}, 32'(ram_addr), 32'(exp_addr));
        check({tag, " ram_wdata"}, ram_wdata, exp_wdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
        rst_n        = 1'b0;
        req_valid    = '0;
        req_lock     = '0;
        req_addr     = '0;
        req_we       = '0;
        req_size     = '0;
        req_unsigned = '0;
        req_wdata    = '0;

        // Reset holds off a pending word write
        set_req(0, 1'b1, 2'b10, 12'h100, 32'hDEADBEEF, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset ready", 32'(req_ready), 32'h0);
        check("reset ram_wr", 32'(ram_wr), 32'h0);
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset rsp_err", 32'(rsp_err), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(1'b0, 32'h0, 1'b0);
        cyc_data("wr_word", 2'b01, 4'b1111, 12'h040, 32'hDEADBEEF);

        // Lanes and extension; mem[0x40] becomes 0x80ADBEEF
        set_req(0, 1'b1, 2'b00, 12'h103, 32'h00000080, 1'b0, 1'b0);
        push(1'b0, 32'h0, 1'b0);
        cyc_data("wr_byte", 2'b01, 4'b1000, 12'h040, 32'h80808080);
        set_req(0, 1'b0, 2'b00, 12'h103, 32'h0, 1'b0, 1'b0);
        push(1'b0, 32'hFFFFFF80, 1'b0);
        cyc("rd_byte_s", 2'b01, 4'b0000);
        set_req(0, 1'b0, 2'b00, 12'h103, 32'h0, 1'b1, 1'b0);
        push(1'b0, 32'h00000080, 1'b0);
        cyc("rd_byte_u", 2'b01, 4'b0000);
        set_req(0, 1'b0, 2'b01, 12'h102, 32'h0, 1'b0, 1'b0);
        push(1'b0, 32'hFFFF80AD, 1'b0);
        cyc("rd_half_s", 2'b01, 4'b0000);
        clr_req(0);

        set_req(1, 1'b0, 2'b01, 12'h100, 32'h0, 1'b1, 1'b0);
        push(1'b1, 32'h0000BEEF, 1'b0);
        cyc("m1_rd_half_u", 2'b10, 4'b0000);
        set_req(1, 1'b0, 2'b00, 12'h101, 32'h0, 1'b0, 1'b0);
        push(1'b1, 32'hFFFFFFBE, 1'b0);
        cyc("m1_rd_byte_s", 2'b10, 4'b0000);
        set_req(1, 1'b1, 2'b01, 12'h106, 32'h00001234, 1'b0, 1'b0);
        push(1'b1, 32'h0, 1'b0);
        cyc_data("m1_wr_half", 2'b10, 4'b1100, 12'h041, 32'h12341234);
        clr_req(1);

        // Round-robin with both masters continuously valid (last grant was M1)
        set_req(0, 1'b0, 2'b10, 12'h104, 32'h0, 1'b0, 1'b0);
        set_req(1, 1'b0, 2'b00, 12'h106, 32'h0, 1'b1, 1'b0);
        push(1'b0, 32'h12340000, 1'b0);
        cyc("rr_0", 2'b01, 4'b0000);
        push(1'b1, 32'h00000034, 1'b0);
        cyc("rr_1", 2'b10, 4'b0000);
        push(1'b0, 32'h12340000, 1'b0);
        cyc("rr_2", 2'b01, 4'b0000);
        push(1'b1, 32'h00000034, 1'b0);
        cyc("rr_3", 2'b10, 4'b0000);
        clr_req(0);
        clr_req(1);

        // Lock: M1 holds the port for three requests while M0 waits
        set_req(0, 1'b1, 2'b00, 12'h108, 32'h0000005A, 1'b0, 1'b0);
        push(1'b0, 32'h0, 1'b0);
        cyc_data("wr_byte_108", 2'b01, 4'b0001, 12'h042, 32'h5A5A5A5A);
        set_req(0, 1'b0, 2'b10, 12'h108, 32'h0, 1'b0, 1'b0);
        set_req(1, 1'b0, 2'b10, 12'h100, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            push(1'b1, 32'h80ADBEEF, 1'b0);
            cyc("lock_m1", 2'b10, 4'b0000);
        end
        clr_req(1);
        push(1'b0, 32'h0000005A, 1'b0);
        cyc("lock_release", 2'b01, 4'b0000);
        clr_req(0);

        // Illegal accesses and the top legal address
        set_req(0, 1'b0, 2'b10, 12'h102, 32'h0, 1'b0, 1'b0);
        push(1'b0, 32'h0, 1'b1);
        cyc("err_word_misalign", 2'b01, 4'b0000);
        set_req(0, 1'b0, 2'b11, 12'h100, 32'h0, 1'b0, 1'b0);
        push(1'b0, 32'h0, 1'b1);
        cyc("err_size", 2'b01, 4'b0000);
        set_req(0, 1'b1, 2'b10, 12'h800, 32'h11111111, 1'b0, 1'b0);
        push(1'b0, 32'h0, 1'b1);
        cyc("err_range", 2'b01, 4'b0000);
        set_req(0, 1'b1, 2'b01, 12'h101, 32'h0000FFFF, 1'b0, 1'b0);
        push(1'b0, 32'h0, 1'b1);
        cyc("err_half_wr", 2'b01, 4'b0000);
        set_req(0, 1'b1, 2'b00, 12'h7FF, 32'h000000C3, 1'b0, 1'b0);
        push(1'b0, 32'h0, 1'b0);
        cyc_data("max_addr_wr", 2'b01, 4'b1000, 12'h1FF, 32'hC3C3C3C3);
        set_req(0, 1'b0, 2'b00, 12'h7FF, 32'h0, 1'b0, 1'b0);
        push(1'b0, 32'hFFFFFFC3, 1'b0);
        cyc("max_addr_rd", 2'b01, 4'b0000);
        clr_req(0);

        // Reset right after a locked M0 read is accepted: its response must vanish
        set_req(0, 1'b0, 2'b10, 12'h100, 32'h0, 1'b0, 1'b1);
        cyc("pre_reset_rd", 2'b01, 4'b0000);
        rst_n = 1'b0;
        clr_req(0);
        repeat (3) begin
            @(negedge clk);
            check("midrst rsp_valid", 32'(rsp_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 2'b10, 12'h100, 32'h0, 1'b0, 1'b0);
        set_req(1, 1'b0, 2'b10, 12'h104, 32'h0, 1'b0, 1'b0);
        push(1'b0, 32'h80ADBEEF, 1'b0);
        cyc("post_rst_tie", 2'b01, 4'b0000);
        push(1'b1, 32'h12340000, 1'b0);
        cyc("post_rst_next", 2'b10, 4'b0000);
        clr_req(0);
        clr_req(1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tcm_port_arbiter.md
Name: tcm_port_arbiter

Overview:
- Shares one port of the dual-port TCM RAM between two requesters: M0 = core load/store unit, M1 = debug/DMA loader.
- Arbitrates round-robin, with an optional lock so a requester can hold the port for a burst.
- Converts byte/half/word requests into RAM word address, byte-lane write strobes and replicated write data.
- Aligns and sign/zero-extends read data from the RAM's 1-cycle synchronous, read-first output, and flags illegal accesses.

Parameters:
- ADDR_WIDTH, $clog2(MAX_PHY_ADDR+1): byte-address width of requests and of the RAM port.
- MAX_ADDR, MAX_PHY_ADDR: highest legal byte address.

Ports:
- clk_i  in  1  single clock; also drives the RAM port clock
- rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  2  per-master request valid (bit0=M0, bit1=M1)
- req_ready_o  out  2  per-master accept; at most one bit set
- req_lock_i  in  2  per-master hold-grant request
- req_addr_i  in  2*ADDR_WIDTH  byte addresses; M0 in the low slice
- req_we_i  in  2  1 = write
- req_size_i  in  4  2 bits per master: 00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  2  1 = zero-extend read data
- req_wdata_i  in  64  write data, low-aligned, 32 bits per master
- rsp_valid_o  out  2  one-cycle response pulse to the owning master
- rsp_rdata_o  out  32  shared response data, qualified by rsp_valid_o
- rsp_err_o  out  1  response error, qualified by rsp_valid_o
- ram_addr_o  out  ADDR_WIDTH  RAM word index, zero-extended
- ram_wdata_o  out  32  RAM write data
- ram_wr_o  out  4  RAM byte write enables
- ram_rdata_i  in  32  RAM read data, valid the cycle after the address is presented

Behaviour:
- Reset values:
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - last_grant=M1, so M0 wins the first tie; lock_owner=none.
  - While rst_n_i=0: req_ready_o=0 and ram_wr_o=0.
- Arbitration (combinational from current inputs plus registered state):
  - If lock_owner is set and that master's req_valid is 1, it is granted.
  - Otherwise, if only one master is valid, it is granted.
  - If both are valid, the master that is not last_grant is granted.
  - req_ready_o = one-hot grant, and only when that master is valid.
- On an accepted handshake (valid & ready):
  - last_grant <= granted master.
  - lock_owner <= granted master if its req_lock_i=1, else none.
  - lock_owner also clears when the owner drops valid.
- Masters hold all request fields stable while valid and not ready.
- Throughput: one access per cycle, no bubbles.
- Latency: the response appears exactly 1 cycle after acceptance, as a pulse on rsp_valid_o[owner].
  - There is no response backpressure; masters must always sink responses.
  - Registered side info for the response: owner, size, addr[1:0], unsigned, we, err.
- Error conditions (evaluated at acceptance):
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr>MAX_ADDR.
  - On error: ram_wr_o=0, the request is still accepted, and the response has err=1 and rdata=0.
- RAM drive for a granted, legal access:
  - ram_addr_o = addr>>2.
  - ram_wr_o = 0000 for reads.
  - Byte write: 0001<<addr[1:0], wdata[7:0] replicated x4.
  - Half write: 0011 or 1100 per addr[1], wdata[15:0] replicated x2.
  - Word write: 1111, wdata as-is.
  - With no grant: ram_wr_o=0; ram_addr_o holds the last value (don't-care).
- Read response:
  - Select the lane of ram_rdata_i by the registered addr[1:0]/size.
  - Sign-extend unless unsigned; word reads ignore the unsigned flag.
  - The RAM is read-first, so a read that follows a same-address write in the next cycle sees the new data. There is no forwarding inside this block.
- Write response: rdata=0, err=0.
- Reset asserted mid-operation: the pending response is discarded (no rsp_valid after reset release) and the lock is cleared.

Test Plan:
- Reset: hold rst_n_i low, drive M0 valid write of word 0xDEADBEEF @0x100 -> ram_wr_o=0, req_ready_o=00. After release, the write is accepted; next cycle rsp_valid_o=01, err=0.
- Lanes/extension:
  - Write byte 0x80 @0x103 -> ram_wr_o=1000, ram_wdata_o=0x80808080.
  - Then signed byte read @0x103 -> rdata=0xFFFFFF80.
  - Unsigned byte read @0x103 -> rdata=0x00000080.
  - Half read @0x102 -> rdata per the stored upper half, sign-extended.
- Round-robin: both masters valid continuously for 4 cycles -> grants M0,M1,M0,M1; rsp_valid_o sequence 01,10,01,10, each one cycle after its grant.
- Lock: M1 valid+lock for 3 requests while M0 is valid -> M1 granted 3 consecutive cycles. M1 then drops lock/valid -> M0 granted next.
- Errors:
  - Word read @0x102 -> ram_wr_o=0, rsp err=1, rdata=0.
  - size=11 -> err=1.
  - Address MAX_ADDR+1 -> err=1, no RAM write.
- Mid-op reset: accept M0 read, assert rst_n_i in the following cycle -> rsp_valid_o stays 00 through reset and after release; the next M0/M1 tie grants M0.
